// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, encodings and state codes for the multicycle CPU control unit.
// Optional mult/div support is selected with CPU_CTRL_MULTDIV_EN.
package cpu_ctrl_pkg;

   localparam int unsigned STACK_INIT      = 227;
   localparam int unsigned EXC_OPCODE_ADDR = 253;
   localparam int unsigned EXC_OVF_ADDR    = 254;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_MFHI = 6'h10;
   localparam logic [5:0] F_MFLO = 6'h12;
   localparam logic [5:0] F_MULT = 6'h18;
   localparam logic [5:0] F_DIV  = 6'h1A;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_SLT  = 6'h2A;

   localparam logic [1:0] ALUB_B    = 2'b00;
   localparam logic [1:0] ALUB_FOUR = 2'b01;
   localparam logic [1:0] ALUB_SEXT = 2'b10;
   localparam logic [1:0] ALUB_SHL2 = 2'b11;

   typedef enum logic [2:0] {
      ALU_LOAD = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010,
      ALU_AND  = 3'b011, ALU_CMP = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      PCS_ALU = 3'b000, PCS_ALUOUT = 3'b001, PCS_JUMP = 3'b010,
      PCS_BYTE = 3'b011, PCS_EPC = 3'b100
   } pc_src_e;

   typedef enum logic [3:0] {
      M2R_ALUOUT = 4'd0, M2R_MDR = 4'd1, M2R_SHIFT = 4'd3, M2R_HI = 4'd4,
      M2R_LO = 4'd5, M2R_PC = 4'd6, M2R_STACK = 4'd8
   } mem_to_reg_e;

   typedef enum logic [1:0] {
      RD_RT = 2'b00, RD_RD = 2'b01, RD_R29 = 2'b10, RD_R31 = 2'b11
   } reg_dst_e;

   typedef enum logic [2:0] {
      SH_NOP = 3'b000, SH_LOAD = 3'b001, SH_SLL = 3'b010,
      SH_SRL = 3'b011, SH_SRA = 3'b100
   } shift_e;

   typedef enum logic [2:0] {
      IORD_PC = 3'b000, IORD_ALUOUT = 3'b001, IORD_VEC = 3'b010
   } iord_e;

   typedef enum logic [5:0] {
      S_RESET = 6'd0, S_FETCH0 = 6'd1, S_FETCH1 = 6'd2, S_FETCH2 = 6'd3,
      S_DECODE = 6'd4, S_R_ALU = 6'd5, S_R_WB = 6'd6, S_SHIFT0 = 6'd7,
      S_SHIFT1 = 6'd8, S_SHIFT_WB = 6'd9, S_ADDI = 6'd10, S_ADDI_WB = 6'd11,
      S_MEM_ADDR = 6'd12, S_LW_WAIT0 = 6'd13, S_LW_WAIT1 = 6'd14, S_LW_WB = 6'd15,
      S_SW = 6'd16, S_BRANCH = 6'd17, S_J = 6'd18, S_JAL = 6'd19, S_JR = 6'd20,
      S_EXC_OPC = 6'd21, S_EXC_OVF = 6'd22, S_EXC_OPC_RD0 = 6'd23,
      S_EXC_OPC_RD1 = 6'd24, S_EXC_OVF_RD0 = 6'd25, S_EXC_OVF_RD1 = 6'd26,
      S_EXC_PC = 6'd27, S_MD_RUN = 6'd28, S_MD_HILO = 6'd29, S_MFHL_WB = 6'd30
   } state_e;

   typedef enum logic [3:0] {
      IC_RALU, IC_SHIFT, IC_JR, IC_ADDI, IC_LW, IC_SW, IC_BRANCH,
      IC_J, IC_JAL, IC_MULTDIV, IC_MFHILO, IC_INVALID
   } instr_class_e;

   typedef struct packed {
      logic        pc_write;
      logic        pc_write_cond;
      logic        eq_or_ne;
      iord_e       iord;
      logic        mem_write;
      logic        ir_write;
      logic        reg_write;
      logic        rega_load;
      logic        regb_load;
      logic        aluout_load;
      logic        epc_write;
      reg_dst_e    reg_dst;
      mem_to_reg_e mem_to_reg;
      logic        alu_src_a;
      logic [1:0]  alu_src_b;
      alu_op_e     alu_op;
      pc_src_e     pc_src;
      shift_e      shift_type;
      logic [1:0]  shift_qnt;
      logic [1:0]  shift_reg;
   } ctrl_t;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Instruction/flag inputs and datapath control outputs of the control unit.
// CPU_CTRL_MULTDIV_EN adds the multiply/divide handshake signals.
interface cpu_control_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       overflow;
   logic       zero;
   logic       PCWrite, PCWriteCond, EQorNE;
   logic [2:0] IorD;
   logic       MemRead_Write;
   logic       IRWrite, RegWrite, RegALoad, RegBLoad, ALUOutLoad, EPCWrite;
   logic [1:0] RegDst;
   logic [3:0] MemtoReg;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp, PCSrc, ShiftType;
   logic [1:0] ShiftQnt, ShiftReg;
`ifdef CPU_CTRL_MULTDIV_EN
   // md_start is held high until md_done; HiLoWrite pulses once afterwards.
   logic       md_start, md_done, HiLoWrite;
`endif

   modport master (
`ifdef CPU_CTRL_MULTDIV_EN
      input  md_done,
      output md_start, HiLoWrite,
`endif
      input  opcode, funct, overflow, zero,
      output PCWrite, PCWriteCond, EQorNE, IorD, MemRead_Write, IRWrite, RegWrite,
             RegALoad, RegBLoad, ALUOutLoad, EPCWrite, RegDst, MemtoReg, ALUSrcA,
             ALUSrcB, ALUOp, PCSrc, ShiftType, ShiftQnt, ShiftReg
   );

   modport slave (
`ifdef CPU_CTRL_MULTDIV_EN
      output md_done,
      input  md_start, HiLoWrite,
`endif
      output opcode, funct, overflow, zero,
      input  PCWrite, PCWriteCond, EQorNE, IorD, MemRead_Write, IRWrite, RegWrite,
             RegALoad, RegBLoad, ALUOutLoad, EPCWrite, RegDst, MemtoReg, ALUSrcA,
             ALUSrcB, ALUOp, PCSrc, ShiftType, ShiftQnt, ShiftReg
   );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode/funct classifier; mult/div classes exist only with
// CPU_CTRL_MULTDIV_EN, otherwise those functs fall to IC_INVALID.
module cpu_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0]   opcode_i,
   input  logic [5:0]   funct_i,
   output instr_class_e class_o,
   output logic         invalid_o,
   output alu_op_e      r_alu_op_o,
   output shift_e       shift_op_o,
   output logic         traps_o
);
   always_comb begin
      class_o    = IC_INVALID;
      r_alu_op_o = ALU_ADD;
      shift_op_o = SH_NOP;
      traps_o    = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               F_ADD: begin class_o = IC_RALU; traps_o = 1'b1; end
               F_SUB: begin class_o = IC_RALU; r_alu_op_o = ALU_SUB; traps_o = 1'b1; end
               F_AND: begin class_o = IC_RALU; r_alu_op_o = ALU_AND; end
               F_SLT: begin class_o = IC_RALU; r_alu_op_o = ALU_CMP; end
               F_SLL: begin class_o = IC_SHIFT; shift_op_o = SH_SLL; end
               F_SRL: begin class_o = IC_SHIFT; shift_op_o = SH_SRL; end
               F_SRA: begin class_o = IC_SHIFT; shift_op_o = SH_SRA; end
               F_JR:  class_o = IC_JR;
`ifdef CPU_CTRL_MULTDIV_EN
               F_MULT, F_DIV: class_o = IC_MULTDIV;
               F_MFHI, F_MFLO: class_o = IC_MFHILO;
`endif
               default: class_o = IC_INVALID;
            endcase
         end
         OP_ADDI: begin class_o = IC_ADDI; traps_o = 1'b1; end
         OP_LW:   class_o = IC_LW;
         OP_SW:   class_o = IC_SW;
         OP_BEQ, OP_BNE: class_o = IC_BRANCH;
         OP_J:    class_o = IC_J;
         OP_JAL:  class_o = IC_JAL;
         default: class_o = IC_INVALID;
      endcase
   end

   assign invalid_o = (class_o == IC_INVALID);
endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle main control FSM: one state per clock, Moore outputs forced to zero
// while rst is low. CPU_CTRL_MULTDIV_EN enables the mult/div/mfhi/mflo flow.
module cpu_control_fsm
   import cpu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   cpu_control_fsm_if.master bus,
   output logic [5:0]        state_o
);
   state_e       state_q, state_d;
   ctrl_t        ctrl_c, ctrl_o;
   instr_class_e iclass;
   logic         invalid, traps, ovf_trap;
   alu_op_e      r_alu_op;
   shift_e       shift_op;
   logic         unused_zero;
`ifdef CPU_CTRL_MULTDIV_EN
   logic         md_start_c, hilo_write_c;
`endif

   cpu_ctrl_decode u_decode (
      .opcode_i   (bus.opcode),
      .funct_i    (bus.funct),
      .class_o    (iclass),
      .invalid_o  (invalid),
      .r_alu_op_o (r_alu_op),
      .shift_op_o (shift_op),
      .traps_o    (traps)
   );

   // zero feeds pc_sel directly; the FSM only selects EQorNE.
   assign unused_zero = bus.zero;
   assign ovf_trap    = traps & bus.overflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_RESET;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctrl_c  = '0;
`ifdef CPU_CTRL_MULTDIV_EN
      md_start_c   = 1'b0;
      hilo_write_c = 1'b0;
`endif
      case (state_q)
         S_RESET: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_R29; ctrl_c.mem_to_reg = M2R_STACK;
            state_d = S_FETCH0;
         end
         S_FETCH0: begin
            ctrl_c.alu_src_b = ALUB_FOUR; ctrl_c.alu_op = ALU_ADD; ctrl_c.pc_write = 1'b1;
            state_d = S_FETCH1;
         end
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: begin ctrl_c.ir_write = 1'b1; state_d = S_DECODE; end
         S_DECODE: begin
            ctrl_c.rega_load = 1'b1; ctrl_c.regb_load = 1'b1; ctrl_c.aluout_load = 1'b1;
            ctrl_c.alu_src_b = ALUB_SHL2; ctrl_c.alu_op = ALU_ADD;
            if (invalid) state_d = S_EXC_OPC;
            else begin
               case (iclass)
                  IC_RALU:       state_d = S_R_ALU;
                  IC_SHIFT:      state_d = S_SHIFT0;
                  IC_JR:         state_d = S_JR;
                  IC_ADDI:       state_d = S_ADDI;
                  IC_LW, IC_SW:  state_d = S_MEM_ADDR;
                  IC_BRANCH:     state_d = S_BRANCH;
                  IC_J:          state_d = S_J;
                  IC_JAL:        state_d = S_JAL;
`ifdef CPU_CTRL_MULTDIV_EN
                  IC_MULTDIV:    state_d = S_MD_RUN;
                  IC_MFHILO:     state_d = S_MFHL_WB;
`endif
                  default:       state_d = S_EXC_OPC;
               endcase
            end
         end
         // An overflowing add/sub/addi diverts to the trap before any writeback.
         S_R_ALU: begin
            ctrl_c.alu_src_a = 1'b1; ctrl_c.alu_src_b = ALUB_B; ctrl_c.alu_op = r_alu_op;
            ctrl_c.aluout_load = !ovf_trap;
            state_d = ovf_trap ? S_EXC_OVF : S_R_WB;
         end
         S_R_WB: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_RD; ctrl_c.mem_to_reg = M2R_ALUOUT;
            state_d = S_FETCH0;
         end
         S_SHIFT0: begin ctrl_c.shift_type = SH_LOAD; state_d = S_SHIFT1; end
         S_SHIFT1: begin ctrl_c.shift_type = shift_op; state_d = S_SHIFT_WB; end
         S_SHIFT_WB: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_RD; ctrl_c.mem_to_reg = M2R_SHIFT;
            state_d = S_FETCH0;
         end
         S_ADDI: begin
            ctrl_c.alu_src_a = 1'b1; ctrl_c.alu_src_b = ALUB_SEXT; ctrl_c.alu_op = ALU_ADD;
            ctrl_c.aluout_load = !ovf_trap;
            state_d = ovf_trap ? S_EXC_OVF : S_ADDI_WB;
         end
         S_ADDI_WB: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_RT; ctrl_c.mem_to_reg = M2R_ALUOUT;
            state_d = S_FETCH0;
         end
         S_MEM_ADDR: begin
            ctrl_c.alu_src_a = 1'b1; ctrl_c.alu_src_b = ALUB_SEXT; ctrl_c.alu_op = ALU_ADD;
            ctrl_c.aluout_load = 1'b1;
            state_d = (iclass == IC_SW) ? S_SW : S_LW_WAIT0;
         end
         S_LW_WAIT0: begin ctrl_c.iord = IORD_ALUOUT; state_d = S_LW_WAIT1; end
         S_LW_WAIT1: begin ctrl_c.iord = IORD_ALUOUT; state_d = S_LW_WB; end
         S_LW_WB: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_RT; ctrl_c.mem_to_reg = M2R_MDR;
            state_d = S_FETCH0;
         end
         S_SW: begin
            ctrl_c.iord = IORD_ALUOUT; ctrl_c.mem_write = 1'b1;
            state_d = S_FETCH0;
         end
         S_BRANCH: begin
            ctrl_c.alu_src_a = 1'b1; ctrl_c.alu_src_b = ALUB_B; ctrl_c.alu_op = ALU_CMP;
            ctrl_c.pc_src = PCS_ALUOUT; ctrl_c.pc_write_cond = 1'b1;
            ctrl_c.eq_or_ne = (bus.opcode == OP_BNE);
            state_d = S_FETCH0;
         end
         S_JAL: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_R31; ctrl_c.mem_to_reg = M2R_PC;
            state_d = S_J;
         end
         S_J: begin ctrl_c.pc_src = PCS_JUMP; ctrl_c.pc_write = 1'b1; state_d = S_FETCH0; end
         S_JR: begin
            ctrl_c.alu_src_a = 1'b1; ctrl_c.alu_op = ALU_LOAD; ctrl_c.pc_src = PCS_ALU;
            ctrl_c.pc_write = 1'b1;
            state_d = S_FETCH0;
         end
         // Each cause has its own read states so the vector byte address is state-selected.
         S_EXC_OPC, S_EXC_OVF: begin
            ctrl_c.epc_write = 1'b1; ctrl_c.alu_src_b = ALUB_FOUR; ctrl_c.alu_op = ALU_SUB;
            state_d = (state_q == S_EXC_OPC) ? S_EXC_OPC_RD0 : S_EXC_OVF_RD0;
         end
         S_EXC_OPC_RD0: begin ctrl_c.iord = IORD_VEC; state_d = S_EXC_OPC_RD1; end
         S_EXC_OPC_RD1: begin ctrl_c.iord = IORD_VEC; state_d = S_EXC_PC; end
         S_EXC_OVF_RD0: begin ctrl_c.iord = IORD_VEC; state_d = S_EXC_OVF_RD1; end
         S_EXC_OVF_RD1: begin ctrl_c.iord = IORD_VEC; state_d = S_EXC_PC; end
         S_EXC_PC: begin ctrl_c.pc_src = PCS_BYTE; ctrl_c.pc_write = 1'b1; state_d = S_FETCH0; end
`ifdef CPU_CTRL_MULTDIV_EN
         S_MD_RUN: begin
            md_start_c = 1'b1;
            if (bus.md_done) state_d = S_MD_HILO;
         end
         S_MD_HILO: begin hilo_write_c = 1'b1; state_d = S_FETCH0; end
         S_MFHL_WB: begin
            ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = RD_RD;
            ctrl_c.mem_to_reg = (bus.funct == F_MFHI) ? M2R_HI : M2R_LO;
            state_d = S_FETCH0;
         end
`endif
         default: state_d = S_FETCH0;
      endcase
   end

   assign ctrl_o = rst ? ctrl_c : '0;

   assign bus.PCWrite       = ctrl_o.pc_write;
   assign bus.PCWriteCond   = ctrl_o.pc_write_cond;
   assign bus.EQorNE        = ctrl_o.eq_or_ne;
   assign bus.IorD          = ctrl_o.iord;
   assign bus.MemRead_Write = ctrl_o.mem_write;
   assign bus.IRWrite       = ctrl_o.ir_write;
   assign bus.RegWrite      = ctrl_o.reg_write;
   assign bus.RegALoad      = ctrl_o.rega_load;
   assign bus.RegBLoad      = ctrl_o.regb_load;
   assign bus.ALUOutLoad    = ctrl_o.aluout_load;
   assign bus.EPCWrite      = ctrl_o.epc_write;
   assign bus.RegDst        = ctrl_o.reg_dst;
   assign bus.MemtoReg      = ctrl_o.mem_to_reg;
   assign bus.ALUSrcA       = ctrl_o.alu_src_a;
   assign bus.ALUSrcB       = ctrl_o.alu_src_b;
   assign bus.ALUOp         = ctrl_o.alu_op;
   assign bus.PCSrc         = ctrl_o.pc_src;
   assign bus.ShiftType     = ctrl_o.shift_type;
   assign bus.ShiftQnt      = ctrl_o.shift_qnt;
   assign bus.ShiftReg      = ctrl_o.shift_reg;
`ifdef CPU_CTRL_MULTDIV_EN
   assign bus.md_start      = rst & md_start_c;
   assign bus.HiLoWrite     = rst & hilo_write_c;
`endif
   assign state_o = state_q;
endmodule
